align_lock_ctrl: RTL and testbench

- Frame-level controller for the src/tx stream alignment stage of the dehaze pipeline.
- Measures, once per frame, the cycle offset between the first src pixel strobe and the first transmission-map pixel strobe. Compares it against the configured src delay and declares lock after N consecutive matching frames.
- Latches the atmospheric light A once per frame so the recovery stage sees a frame-stable value.
- Downstream recovery is enabled only while locked.

---
 rtl/align_lock_ctrl_pkg.sv | 15 +
 rtl/align_lock_ctrl_if.sv | 36 +++
 rtl/align_lock_ctrl_sof_edge_det.sv | 18 +
 rtl/align_lock_ctrl.sv | 136 +++++++++++++
 tb/tb_align_lock_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/align_lock_ctrl_pkg.sv
// Shared definitions for the src/tx alignment lock controller of the dehaze pipeline.
// Holds the FSM encoding and the fixed datapath widths.
package align_lock_ctrl_pkg;

    localparam int A_W         = 8;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2,
        CHECK = 2'd3
    } state_e;

endpackage

// File: rtl/align_lock_ctrl_if.sv
// Stream-sync, configuration and status bundle between the alignment stage and the lock controller.
// Strobes are level-sampled at every clk edge; there is no backpressure, the controller always accepts.
interface align_lock_if #(
    parameter int CNT_W = 8
);
    import align_lock_ctrl_pkg::*;

    logic                   src_vsync;
    logic                   src_clken;
    logic                   tx_vsync;
    logic                   tx_clken;
    logic [A_W-1:0]         pre_A;
    logic                   clr_err;
    logic [A_W-1:0]         a_frame;
    logic                   locked;
    logic                   meas_valid;
    logic [CNT_W-1:0]       meas_delay;
    logic                   err_mismatch;
    logic                   err_timeout;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    state_e                 dbg_state;
    logic                   dbg_tx_seen;

    modport master (
        output src_vsync, src_clken, tx_vsync, tx_clken, pre_A, clr_err,
        input  a_frame, locked, meas_valid, meas_delay, err_mismatch, err_timeout,
               frame_cnt, dbg_state, dbg_tx_seen
    );

    modport slave (
        input  src_vsync, src_clken, tx_vsync, tx_clken, pre_A, clr_err,
        output a_frame, locked, meas_valid, meas_delay, err_mismatch, err_timeout,
               frame_cnt, dbg_state, dbg_tx_seen
    );

endinterface

// File: rtl/align_lock_ctrl_sof_edge_det.sv
// Registered rising-edge detector for a frame sync line; sof_o pulses for the first high cycle.
module sof_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sync_i,
    output logic sof_o
);

    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 1'b0;
        else     sync_q <= sync_i;
    end

    assign sof_o = sync_i & ~sync_q;

endmodule

// File: rtl/align_lock_ctrl.sv
// Measures the src-to-tx first-strobe offset once per frame, declares lock after LOCK_FRAMES
// consecutive matches, and holds a frame-stable copy of the atmospheric light A.
module align_lock_ctrl
    import align_lock_ctrl_pkg::*;
#(
    parameter int EXP_DELAY   = 6,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 8,
    parameter int MAX_WAIT    = 255
) (
    input  logic         clk,
    input  logic         rst,
    align_lock_if.slave  bus
);

    localparam int MATCH_W = $clog2(LOCK_FRAMES + 1);

    logic                   src_sof;
    logic                   tx_sof;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       meas_delay_q;
    logic [MATCH_W-1:0]     match_cnt_q;
    logic [MATCH_W-1:0]     match_inc_d;
    logic                   lock_reached_d;
    logic                   locked_q;
    logic                   meas_valid_q;
    logic                   err_mismatch_q;
    logic                   err_timeout_q;
    logic                   tx_seen_q;
    logic [A_W-1:0]         a_frame_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    sof_edge_det u_src_sof (.clk(clk), .rst(rst), .sync_i(bus.src_vsync), .sof_o(src_sof));
    sof_edge_det u_tx_sof  (.clk(clk), .rst(rst), .sync_i(bus.tx_vsync),  .sof_o(tx_sof));

    assign match_inc_d    = (match_cnt_q == MATCH_W'(LOCK_FRAMES)) ? match_cnt_q
                                                                   : match_cnt_q + MATCH_W'(1);
    assign lock_reached_d = (32'(match_cnt_q) + 32'd1) >= 32'(LOCK_FRAMES);

    // tx frame presence is only tracked for observation; it never steers the measurement.
    always_ff @(posedge clk) begin
        if (rst)           tx_seen_q <= 1'b0;
        else if (tx_sof)   tx_seen_q <= 1'b1;
        else if (src_sof)  tx_seen_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            meas_delay_q   <= '0;
            match_cnt_q    <= '0;
            locked_q       <= 1'b0;
            meas_valid_q   <= 1'b0;
            err_mismatch_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            a_frame_q      <= '0;
            frame_cnt_q    <= '0;
        end else begin
            meas_valid_q <= 1'b0;
            // Clear first so an error raised in the same cycle overrides it.
            if (bus.clr_err) begin
                err_mismatch_q <= 1'b0;
                err_timeout_q  <= 1'b0;
            end
            if (src_sof) begin
                a_frame_q   <= bus.pre_A;
                frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (src_sof) state_q <= ARMED;
                end
                ARMED: begin
                    if (src_sof) begin
                        err_timeout_q <= 1'b1;
                        locked_q      <= 1'b0;
                        match_cnt_q   <= '0;
                    end else if (bus.src_clken && bus.tx_clken) begin
                        cnt_q        <= '0;
                        meas_delay_q <= '0;
                        meas_valid_q <= 1'b1;
                        state_q      <= CHECK;
                    end else if (bus.src_clken) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (src_sof) begin
                        err_timeout_q <= 1'b1;
                        locked_q      <= 1'b0;
                        match_cnt_q   <= '0;
                        state_q       <= ARMED;
                    end else if (bus.tx_clken) begin
                        meas_delay_q <= cnt_q;
                        meas_valid_q <= 1'b1;
                        state_q      <= CHECK;
                    end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
                        err_timeout_q <= 1'b1;
                        locked_q      <= 1'b0;
                        match_cnt_q   <= '0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (cnt_q == CNT_W'(EXP_DELAY)) begin
                        match_cnt_q <= match_inc_d;
                        if (lock_reached_d) locked_q <= 1'b1;
                    end else begin
                        err_mismatch_q <= 1'b1;
                        locked_q       <= 1'b0;
                        match_cnt_q    <= '0;
                    end
                    state_q <= src_sof ? ARMED : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a_frame      = a_frame_q;
    assign bus.locked       = locked_q;
    assign bus.meas_valid   = meas_valid_q;
    assign bus.meas_delay   = meas_delay_q;
    assign bus.err_mismatch = err_mismatch_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.dbg_state    = state_q;
    assign bus.dbg_tx_seen  = tx_seen_q;

endmodule

// File: tb/tb_align_lock_ctrl.sv
// Directed bench for align_lock_ctrl: lock acquisition, mismatch, timeout, abort, reset and clear.
module tb_align_lock_ctrl;
    import align_lock_ctrl_pkg::*;

    localparam int EXP_DELAY   = 6;
    localparam int LOCK_FRAMES = 2;
    localparam int CNT_W       = 8;
    localparam int MAX_WAIT    = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    align_lock_if #(.CNT_W(CNT_W)) bus ();

    align_lock_ctrl #(
        .EXP_DELAY  (EXP_DELAY),
        .LOCK_FRAMES(LOCK_FRAMES),
        .CNT_W      (CNT_W),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sof_pulse(input logic [7:0] a);
        bus.src_vsync = 1'b1;
        bus.tx_vsync  = 1'b1;
        bus.pre_A     = a;
        step(1);
        bus.src_vsync = 1'b0;
        bus.tx_vsync  = 1'b0;
    endtask

    // First src strobe now, first tx strobe d cycles later; returns in the CHECK cycle.
    task automatic run_meas(input int d);
        bus.src_clken = 1'b1;
        bus.tx_clken  = (d == 0);
        step(1);
        bus.src_clken = 1'b0;
        bus.tx_clken  = 1'b0;
        if (d > 0) begin
            step(d - 1);
            bus.tx_clken = 1'b1;
            step(1);
            bus.tx_clken = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        step(1);
        bus.clr_err = 1'b0;
    endtask

    initial begin
        bus.src_vsync = 1'b0;
        bus.src_clken = 1'b0;
        bus.tx_vsync  = 1'b0;
        bus.tx_clken  = 1'b0;
        bus.pre_A     = 8'h00;
        bus.clr_err   = 1'b0;

        step(2);
        rst = 1'b0;
        check("rst_locked",    16'(bus.locked),       16'h0);
        check("rst_frame_cnt", bus.frame_cnt,         16'h0);
        check("rst_a_frame",   16'(bus.a_frame),      16'h0);
        check("rst_meas",      16'(bus.meas_valid),   16'h0);
        check("rst_errs",      16'({bus.err_mismatch, bus.err_timeout}), 16'h0);
        check("rst_state",     16'(bus.dbg_state),    16'(IDLE));

        // Frame 1: good offset, not yet locked
        step(2);
        sof_pulse(8'hC8);
        check("f1_armed", 16'(bus.dbg_state), 16'(ARMED));
        step(1);
        run_meas(6);
        check("f1_meas_valid", 16'(bus.meas_valid), 16'h1);
        check("f1_meas_delay", 16'(bus.meas_delay), 16'd6);
        check("f1_a_frame",    16'(bus.a_frame),    16'hC8);
        check("f1_frame_cnt",  bus.frame_cnt,       16'd1);
        step(1);
        check("f1_locked",     16'(bus.locked),     16'h0);
        check("f1_valid_drop", 16'(bus.meas_valid), 16'h0);

        // Frame 2: second match locks
        step(3);
        sof_pulse(8'hC8);
        run_meas(6);
        check("f2_meas_delay", 16'(bus.meas_delay), 16'd6);
        check("f2_pre_lock",   16'(bus.locked),     16'h0);
        step(1);
        check("f2_locked",     16'(bus.locked),     16'h1);
        check("f2_errs",       16'({bus.err_mismatch, bus.err_timeout}), 16'h0);
        check("f2_frame_cnt",  bus.frame_cnt,       16'd2);

        // Frame 3: offset 5 breaks lock
        step(3);
        sof_pulse(8'h40);
        run_meas(5);
        check("f3_meas_delay", 16'(bus.meas_delay), 16'd5);
        check("f3_a_frame",    16'(bus.a_frame),    16'h40);
        step(1);
        check("f3_mismatch",   16'(bus.err_mismatch), 16'h1);
        check("f3_unlocked",   16'(bus.locked),       16'h0);

        // Frames 4 and 5 relock; sticky error survives until cleared
        step(3);
        sof_pulse(8'h41);
        run_meas(6);
        step(1);
        check("f4_locked", 16'(bus.locked), 16'h0);
        step(3);
        sof_pulse(8'h42);
        run_meas(6);
        step(1);
        check("f5_locked",   16'(bus.locked),       16'h1);
        check("f5_mismatch", 16'(bus.err_mismatch), 16'h1);
        pulse_clr();
        check("clr_mismatch", 16'(bus.err_mismatch), 16'h0);
        check("clr_locked",   16'(bus.locked),       16'h1);

        // Frame 6: simultaneous strobes measure zero
        step(3);
        sof_pulse(8'h43);
        run_meas(0);
        check("f6_meas_delay", 16'(bus.meas_delay), 16'd0);
        check("f6_meas_valid", 16'(bus.meas_valid), 16'h1);
        step(1);
        check("f6_mismatch",  16'(bus.err_mismatch), 16'h1);
        check("f6_unlocked",  16'(bus.locked),       16'h0);
        check("f6_frame_cnt", bus.frame_cnt,         16'd6);

        // Frame 7: no tx strobe, timeout MAX_WAIT cycles after first src strobe
        step(3);
        sof_pulse(8'h44);
        bus.src_clken = 1'b1;
        step(1);
        bus.src_clken = 1'b0;
        step(MAX_WAIT - 1);
        check("to_not_yet",  16'(bus.err_timeout), 16'h0);
        check("to_counting", 16'(bus.dbg_state),   16'(COUNT));
        step(1);
        check("to_flag",     16'(bus.err_timeout), 16'h1);
        check("to_idle",     16'(bus.dbg_state),   16'(IDLE));
        check("to_no_valid", 16'(bus.meas_valid),  16'h0);
        pulse_clr();
        check("to_cleared",  16'({bus.err_mismatch, bus.err_timeout}), 16'h0);

        // Frame 8 aborted by frame 9 mid-count; frame 9 measures normally
        step(2);
        sof_pulse(8'h45);
        bus.src_clken = 1'b1;
        step(1);
        bus.src_clken = 1'b0;
        step(3);
        sof_pulse(8'h55);
        check("ab_timeout",   16'(bus.err_timeout), 16'h1);
        check("ab_armed",     16'(bus.dbg_state),   16'(ARMED));
        check("ab_frame_cnt", bus.frame_cnt,        16'd9);
        run_meas(6);
        check("ab_meas_delay", 16'(bus.meas_delay), 16'd6);
        check("ab_a_frame",    16'(bus.a_frame),    16'h55);

        // Reset during COUNT
        step(3);
        sof_pulse(8'h66);
        bus.src_clken = 1'b1;
        step(1);
        bus.src_clken = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mr_state",     16'(bus.dbg_state),  16'(IDLE));
        check("mr_frame_cnt", bus.frame_cnt,       16'h0);
        check("mr_a_frame",   16'(bus.a_frame),    16'h0);
        check("mr_delay",     16'(bus.meas_delay), 16'h0);
        check("mr_flags",     16'({bus.locked, bus.meas_valid, bus.err_mismatch, bus.err_timeout}), 16'h0);

        // clr_err coincident with a mismatch: set wins
        step(2);
        sof_pulse(8'h33);
        run_meas(5);
        check("cc_meas_delay", 16'(bus.meas_delay), 16'd5);
        bus.clr_err = 1'b1;
        step(1);
        bus.clr_err = 1'b0;
        check("cc_mismatch",  16'(bus.err_mismatch), 16'h1);
        check("cc_locked",    16'(bus.locked),       16'h0);
        check("cc_frame_cnt", bus.frame_cnt,         16'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
